cv32e40p_cluster_event_unit: RTL and testbench



---
 rtl/cv32e40p_cluster_event_unit.sv | 176 +++++++++++++++++
 tb/tb_cv32e40p_cluster_event_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_cluster_event_unit.sv
// cv32e40p_cluster_event_unit
//
// Purpose:
//   Cluster-side responder to the core's sleep interface. It latches external
//   event strobes into a pending register and serves cv.elw event-wait loads.
//   It gates the core's clock through pulp_clock_en_i while the core sleeps
//   inside an elw. It also sequences fetch_enable after reset and forwards
//   debug requests only while the core clock runs. The block sits on the
//   free-running clock, outside the core's clock gate.
//
// Ports:
//   clk_i           free-running clock
//   rst_n           synchronous active-low reset
//   event_i         event strobes, sampled every cycle
//   mask_we_i       event mask write strobe
//   mask_wdata_i    new event mask value
//   core_sleep_i    core_sleep_o from the core
//   clock_en_o      to the core's pulp_clock_en_i (combinational)
//   fetch_enable_o  to the core's fetch_enable_i (sticky after boot delay)
//   elw_req_i       cv.elw load request
//   elw_gnt_o       grant; high only while no request is outstanding
//   elw_rvalid_o    one-cycle load response valid
//   elw_rdata_o     masked pending events, zero-extended
//   debug_req_i     external debug request
//   debug_req_o     debug request forwarded to the core
//
// Optional feature (macro CV32E40P_EVT_SLEEP_CNT_EN):
//   sleep_cnt_clr_i  clears the sleep cycle counter (wins over increment)
//   sleep_cycles_o   saturating count of cycles with clock_en_o=0

module cv32e40p_cluster_event_unit #(
  parameter int unsigned NUM_EVENTS = 8,
  parameter logic [31:0] MASK_RESET = 32'hFFFF_FFFF,
  parameter int unsigned BOOT_DELAY = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  mask_we_i,
  input  logic [NUM_EVENTS-1:0] mask_wdata_i,
  input  logic                  core_sleep_i,
  output logic                  clock_en_o,
  output logic                  fetch_enable_o,
  input  logic                  elw_req_i,
  output logic                  elw_gnt_o,
  output logic                  elw_rvalid_o,
  output logic [31:0]           elw_rdata_o,
  input  logic                  debug_req_i,
  output logic                  debug_req_o
`ifdef CV32E40P_EVT_SLEEP_CNT_EN
  ,
  input  logic                  sleep_cnt_clr_i,
  output logic [31:0]           sleep_cycles_o
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SLEEP,
    S_WAKE,
    S_RESP
  } state_e;

  state_e                r_state;
  state_e                w_stateNext;
  logic [NUM_EVENTS-1:0] r_pending;
  logic [NUM_EVENTS-1:0] r_mask;
  logic [NUM_EVENTS-1:0] w_respBits;
  logic [NUM_EVENTS-1:0] w_clr;
  logic                  w_hit;
  logic                  w_clockEn;
  logic [7:0]            r_bootCnt;
  logic                  r_fetchEn;
  logic                  r_gnt;
  logic                  r_rvalid;
  logic [31:0]           w_rdataExt;

  assign w_respBits = r_pending & r_mask;

  // An event strobe arriving this cycle already counts as a hit, so a sleeping
  // core gets its clock back in the very cycle the event shows up.
  assign w_hit = |((r_pending | event_i) & r_mask);

  assign w_clockEn = !((r_state == S_SLEEP) && core_sleep_i && !w_hit && !debug_req_i);

  // Only the bits returned in the response are cleared; the mask register
  // value is the one from before any same-cycle mask write.
  assign w_clr = (r_state == S_RESP) ? w_respBits : '0;

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_IDLE:  if (elw_req_i) w_stateNext = S_WAIT;
      S_WAIT: begin
        if (w_hit)             w_stateNext = S_RESP;
        else if (core_sleep_i) w_stateNext = S_SLEEP;
      end
      S_SLEEP: begin
        if (w_hit)                             w_stateNext = S_WAKE;
        else if (debug_req_i || !core_sleep_i) w_stateNext = S_WAIT;
      end
      S_WAKE:  w_stateNext = S_RESP;
      S_RESP:  w_stateNext = S_IDLE;
      default: w_stateNext = S_IDLE;
    endcase
  end

  // FSM with registered grant and response-valid decoded from the next state.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= 1'b1;
      r_rvalid <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_gnt    <= (w_stateNext == S_IDLE);
      r_rvalid <= (w_stateNext == S_RESP);
    end
  end

  // Set wins over clear: an event re-pulsed in the response cycle survives.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_mask    <= MASK_RESET[NUM_EVENTS-1:0];
    end else begin
      r_pending <= (r_pending & ~w_clr) | event_i;
      if (mask_we_i) r_mask <= mask_wdata_i;
    end
  end

  // The counter stops at BOOT_DELAY; fetch enable is set on the edge that
  // sees the count there, so BOOT_DELAY=0 enables fetch right after the
  // first edge out of reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_bootCnt <= 8'd0;
      r_fetchEn <= 1'b0;
    end else if (r_bootCnt == 8'(BOOT_DELAY)) begin
      r_fetchEn <= 1'b1;
    end else begin
      r_bootCnt <= r_bootCnt + 8'd1;
    end
  end

  always_comb begin
    w_rdataExt                   = '0;
    w_rdataExt[NUM_EVENTS-1:0]   = w_respBits;
  end

  assign clock_en_o     = w_clockEn;
  assign fetch_enable_o = r_fetchEn;
  assign elw_gnt_o      = r_gnt;
  assign elw_rvalid_o   = r_rvalid;
  assign elw_rdata_o    = r_rvalid ? w_rdataExt : 32'd0;
  assign debug_req_o    = debug_req_i & w_clockEn;

`ifdef CV32E40P_EVT_SLEEP_CNT_EN
  logic [31:0] r_sleepCnt;

  // Saturating count of gated-clock cycles; a clear has priority.
  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      r_sleepCnt <= 32'd0;
    end else if (sleep_cnt_clr_i) begin
      r_sleepCnt <= 32'd0;
    end else if (!w_clockEn && (r_sleepCnt != 32'hFFFF_FFFF)) begin
      r_sleepCnt <= r_sleepCnt + 32'd1;
    end
  end

  assign sleep_cycles_o = r_sleepCnt;
`endif

endmodule

// File: tb/tb_cv32e40p_cluster_event_unit.sv
// tb_cv32e40p_cluster_event_unit
//
// Purpose:
//   Self-checking bench for cv32e40p_cluster_event_unit (default build, optional
//   sleep counter absent). Directed scenarios followed by random traffic, all
//   compared every cycle against a transaction-level reference model.

module tb_cv32e40p_cluster_event_unit;

  localparam int NE = 8;
  localparam int BD = 4;

  logic          clk_i = 1'b0;
  logic          rst_n;
  logic [NE-1:0] event_i;
  logic          mask_we_i;
  logic [NE-1:0] mask_wdata_i;
  logic          core_sleep_i;
  logic          clock_en_o;
  logic          fetch_enable_o;
  logic          elw_req_i;
  logic          elw_gnt_o;
  logic          elw_rvalid_o;
  logic [31:0]   elw_rdata_o;
  logic          debug_req_i;
  logic          debug_req_o;

  int testsRun    = 0;
  int testsFailed = 0;

  // Reference model: the outstanding request is described by what it is
  // currently doing, not by an encoded state.
  bit [NE-1:0] mPending;
  bit [NE-1:0] mMask;
  int          mEdges;
  bit          mBusy;
  bit          mAsleep;
  bit          mWaking;
  bit          mResponding;

  logic [31:0] lastRdata;
  logic        lastRvalid;
  logic        lastClkEn;
  logic        lastDbgO;
  logic        lastGnt;

  always #5 clk_i = ~clk_i;

  cv32e40p_cluster_event_unit #(
    .NUM_EVENTS(NE),
    .MASK_RESET(32'hFFFF_FFFF),
    .BOOT_DELAY(BD)
  ) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .event_i       (event_i),
    .mask_we_i     (mask_we_i),
    .mask_wdata_i  (mask_wdata_i),
    .core_sleep_i  (core_sleep_i),
    .clock_en_o    (clock_en_o),
    .fetch_enable_o(fetch_enable_o),
    .elw_req_i     (elw_req_i),
    .elw_gnt_o     (elw_gnt_o),
    .elw_rvalid_o  (elw_rvalid_o),
    .elw_rdata_o   (elw_rdata_o),
    .debug_req_i   (debug_req_i),
    .debug_req_o   (debug_req_o)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mPending    = '0;
    mMask       = '1;
    mEdges      = 0;
    mBusy       = 0;
    mAsleep     = 0;
    mWaking     = 0;
    mResponding = 0;
  endtask

  function automatic bit modelHit();
    return |((mPending | event_i) & mMask);
  endfunction

  // Compares every output against what the model predicts for this cycle.
  task automatic checkOutput();
    bit          expClk;
    logic [31:0] expData;
    expClk  = !(mAsleep && core_sleep_i && !modelHit() && !debug_req_i);
    expData = mResponding ? {24'd0, mPending & mMask} : 32'd0;
    checkVal("clock_en", {31'd0, clock_en_o}, {31'd0, expClk});
    checkVal("fetch_en", {31'd0, fetch_enable_o}, {31'd0, (mEdges > BD)});
    checkVal("gnt", {31'd0, elw_gnt_o}, {31'd0, !mBusy});
    checkVal("rvalid", {31'd0, elw_rvalid_o}, {31'd0, mResponding});
    checkVal("rdata", elw_rdata_o, expData);
    checkVal("debug_req_o", {31'd0, debug_req_o}, {31'd0, debug_req_i & expClk});
    lastRdata  = elw_rdata_o;
    lastRvalid = elw_rvalid_o;
    lastClkEn  = clock_en_o;
    lastDbgO   = debug_req_o;
    lastGnt    = elw_gnt_o;
  endtask

  task automatic modelEdge();
    bit          hit;
    bit [NE-1:0] nextPending;
    if (!rst_n) begin
      modelReset();
      return;
    end
    hit         = modelHit();
    nextPending = mPending | event_i;
    if (mEdges < 1000) mEdges++;
    if (mResponding) begin
      nextPending = (mPending & ~(mPending & mMask)) | event_i;
      mResponding = 0;
      mBusy       = 0;
    end else if (!mBusy) begin
      if (elw_req_i) mBusy = 1;
    end else if (mWaking) begin
      mWaking     = 0;
      mResponding = 1;
    end else if (mAsleep) begin
      if (hit) begin
        mAsleep = 0;
        mWaking = 1;
      end else if (debug_req_i || !core_sleep_i) begin
        mAsleep = 0;
      end
    end else begin
      if (hit)               mResponding = 1;
      else if (core_sleep_i) mAsleep = 1;
    end
    mPending = nextPending;
    if (mask_we_i) mMask = mask_wdata_i;
  endtask

  // One full cycle: drive inputs, check at the falling edge, advance the model
  // on the rising edge.
  task automatic applyStimulus(input bit rst, input bit [NE-1:0] ev, input bit we,
                               input bit [NE-1:0] wd, input bit sleep, input bit req,
                               input bit dbg);
    rst_n        = rst;
    event_i      = ev;
    mask_we_i    = we;
    mask_wdata_i = wd;
    core_sleep_i = sleep;
    elw_req_i    = req;
    debug_req_i  = dbg;
    @(negedge clk_i);
    checkOutput();
    @(posedge clk_i);
    modelEdge();
    #1;
  endtask

  initial begin
    bit sleepR;
    rst_n = 0; event_i = '0; mask_we_i = 0; mask_wdata_i = '0;
    core_sleep_i = 0; elw_req_i = 0; debug_req_i = 0;
    repeat (2) @(posedge clk_i);
    modelReset();
    #1;

    // Boot sequencing and clock enable after release.
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("boot sticky fetch", {31'd0, fetch_enable_o}, 32'd1);

    // Already-pending event bit2 served without sleeping.
    applyStimulus(1, 8'h04, 1, 8'hFF, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("tp2 rvalid", {31'd0, lastRvalid}, 32'd1);
    checkVal("tp2 rdata", lastRdata, 32'h4);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);

    // Sleep with no events, then wake on event bit5.
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 10; i++) applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkVal("tp3 asleep clk", {31'd0, lastClkEn}, 32'd0);
    applyStimulus(1, 8'h20, 0, 0, 1, 0, 0);
    checkVal("tp3 wake same cycle", {31'd0, lastClkEn}, 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("tp3 rdata", lastRdata, 32'h20);

    // Masked event keeps the core asleep until the mask opens.
    applyStimulus(1, 0, 1, 8'h01, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 8'h08, 0, 0, 1, 0, 0);
    checkVal("tp4 masked clk", {31'd0, lastClkEn}, 32'd0);
    applyStimulus(1, 0, 1, 8'h08, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkVal("tp4 unmask wake", {31'd0, lastClkEn}, 32'd1);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("tp4 rdata", lastRdata, 32'h08);

    // Debug request while asleep.
    applyStimulus(1, 0, 1, 8'hFF, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 1);
    checkVal("tp5 dbg clk", {31'd0, lastClkEn}, 32'd1);
    checkVal("tp5 dbg fwd", {31'd0, lastDbgO}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 1, 0, 0);
    checkVal("tp5 no rvalid", {31'd0, lastRvalid}, 32'd0);
    applyStimulus(1, 8'h01, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("tp5 rdata", lastRdata, 32'h01);

    // Event re-pulsed in the response cycle survives the clear.
    applyStimulus(1, 8'h02, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 8'h02, 0, 0, 0, 0, 0);
    checkVal("tp6 rdata", lastRdata, 32'h02);
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    checkVal("tp6 kept bit1", lastRdata, 32'h02);

    // Reset asserted mid-sleep.
    applyStimulus(1, 0, 0, 0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(1, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    checkVal("rst clk_en", {31'd0, lastClkEn}, 32'd1);
    checkVal("rst gnt", {31'd0, lastGnt}, 32'd1);
    checkVal("rst fetch", {31'd0, fetch_enable_o}, 32'd0);

    // Random traffic against the model.
    sleepR = 0;
    for (int i = 0; i < 800; i++) begin
      bit          rstR;
      bit [NE-1:0] evR;
      rstR = ($urandom_range(0, 299) != 0);
      evR  = ($urandom_range(0, 5) == 0) ? NE'(1 << $urandom_range(0, NE - 1)) : '0;
      if ($urandom_range(0, 4) == 0) sleepR = ~sleepR;
      applyStimulus(rstR, evR, ($urandom_range(0, 15) == 0), NE'($urandom),
                    sleepR, $urandom_range(0, 1) == 1, ($urandom_range(0, 19) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
